// File: rtl/pg_loader_pkg.sv
// Shared definitions for the UART program loader.
// Checksum check is built in when PG_LOADER_CKSUM_EN is defined.
package pg_loader_pkg;

    typedef enum logic [2:0] {
        F_IDLE,
        F_LEN_LO,
        F_LEN_HI,
        F_DAT_LO,
        F_DAT_HI,
        F_CKSUM,
        F_DONE,
        F_ERR
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int unsigned CKSUM_W = 8;

    function automatic logic frame_active(input frame_state_t s);
        return !(s == F_IDLE || s == F_DONE || s == F_ERR);
    endfunction

endpackage

// File: rtl/pg_uart_loader_if.sv
// Program-RAM write port bundle with loader status.
// The loader drives it (master); a RAM/monitor observes it (slave).
interface pg_prog_if;
    logic        pg_rst;
    logic        pg_wen;
    logic [15:0] pg_din;
    logic [15:0] pg_adr;
    logic        pg_done;
    logic        err;
    logic        busy;

    modport master (
        output pg_rst, pg_wen, pg_din, pg_adr,
        output pg_done, err, busy
    );
    modport slave (
        input pg_rst, pg_wen, pg_din, pg_adr,
        input pg_done, err, busy
    );
endinterface

// File: rtl/pg_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and framing-error flag.
module pg_uart_rx #(
    parameter int unsigned DIV = 86
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int unsigned CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    rx_state_t     r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic          r_valid, w_valid;
    logic          r_ferr, w_ferr;
    logic          w_rx;
    logic          w_fall;

    assign w_rx   = r_sync[1];
    assign w_fall = r_prev & ~w_rx;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state = RX_START;
                    w_cnt   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == HALF) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = w_rx ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL) begin
                    w_cnt   = '0;
                    w_shift = {w_rx, r_shift[7:1]};
                    w_bit   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state = RX_STOP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == FULL) begin
                    w_cnt   = '0;
                    w_state = RX_IDLE;
                    w_valid = w_rx;
                    w_ferr  = ~w_rx;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: w_state = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx_i};
            r_prev  <= w_rx;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
        end
    end

    assign byte_o       = r_shift;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_ferr;
endmodule

// File: rtl/pg_uart_loader.sv
// UART frame loader: A5, N(16 LE), N words (LE), optional checksum.
// Define PG_LOADER_CKSUM_EN to enable the trailing checksum check.
module pg_uart_loader
    import pg_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        uart_rx_i,
    output logic        pg_rst_o,
    output logic        pg_wen_o,
    output logic [15:0] pg_din_o,
    output logic [15:0] pg_adr_o,
    output logic        pg_done_o,
    output logic        err_o,
    output logic        busy_o
);
    localparam int unsigned DIV = CLK_HZ / BAUD;

    logic [7:0] w_byte;
    logic       w_bv;
    logic       w_ferr;

    pg_uart_rx #(.DIV(DIV)) u_rx (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .rx_i         (uart_rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_bv),
        .frame_err_o  (w_ferr)
    );

    frame_state_t       r_state, w_state;
    logic [15:0]        r_cnt, w_cnt;
    logic [7:0]         r_lo, w_lo;
    logic [CKSUM_W-1:0] r_sum, w_sum;
    logic [15:0]        r_adr, w_adr;
    logic [15:0]        r_din, w_din;
    logic               r_wen, w_wen;
    logic               r_rst, w_rst;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               w_active;
    logic [15:0]        w_len;

    assign w_active = frame_active(r_state);
    assign w_len    = {w_byte, r_cnt[7:0]};

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_lo    = r_lo;
        w_sum   = r_sum;
        w_adr   = r_adr;
        w_din   = r_din;
        w_wen   = 1'b0;
        w_rst   = 1'b0;
        w_done  = r_done;
        w_err   = r_err;
        // address advances on the cycle after the write strobe
        if (r_wen) w_adr = r_adr + 16'd1;
        if (w_bv) begin
            unique case (r_state)
                F_IDLE, F_DONE, F_ERR: begin
                    if (w_byte == SYNC_BYTE) begin
                        w_state = F_LEN_LO;
                        w_rst   = 1'b1;
                        w_done  = 1'b0;
                        w_err   = 1'b0;
                        w_sum   = '0;
                        w_adr   = '0;
                    end
                end
                F_LEN_LO: begin
                    w_cnt   = {8'h00, w_byte};
                    w_state = F_LEN_HI;
                end
                F_LEN_HI: begin
                    w_cnt = w_len;
                    if (w_len == 16'd0) begin
`ifdef PG_LOADER_CKSUM_EN
                        w_state = F_CKSUM;
`else
                        w_state = F_DONE;
                        w_done  = 1'b1;
`endif
                    end else begin
                        w_state = F_DAT_LO;
                    end
                end
                F_DAT_LO: begin
                    w_lo    = w_byte;
                    w_sum   = r_sum + w_byte;
                    w_state = F_DAT_HI;
                end
                F_DAT_HI: begin
                    w_din = {w_byte, r_lo};
                    w_wen = 1'b1;
                    w_sum = r_sum + w_byte;
                    w_cnt = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
`ifdef PG_LOADER_CKSUM_EN
                        w_state = F_CKSUM;
`else
                        w_state = F_DONE;
                        w_done  = 1'b1;
`endif
                    end else begin
                        w_state = F_DAT_LO;
                    end
                end
                F_CKSUM: begin
`ifdef PG_LOADER_CKSUM_EN
                    if (w_byte == r_sum) begin
                        w_state = F_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = F_ERR;
                        w_err   = 1'b1;
                    end
`else
                    w_state = F_IDLE;
`endif
                end
                default: w_state = F_IDLE;
            endcase
        end else if (w_ferr && w_active) begin
            w_state = F_ERR;
            w_err   = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= F_IDLE;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_sum   <= '0;
            r_adr   <= '0;
            r_din   <= '0;
            r_wen   <= 1'b0;
            r_rst   <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_lo    <= w_lo;
            r_sum   <= w_sum;
            r_adr   <= w_adr;
            r_din   <= w_din;
            r_wen   <= w_wen;
            r_rst   <= w_rst;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign pg_rst_o  = r_rst;
    assign pg_wen_o  = r_wen;
    assign pg_din_o  = r_din;
    assign pg_adr_o  = r_adr;
    assign pg_done_o = r_done;
    assign err_o     = r_err;
    assign busy_o    = w_active;
endmodule

// File: tb/tb_pg_uart_loader.sv
// Directed frames into pg_uart_loader; expected writes via scoreboard.
module tb_pg_uart_loader;
    import pg_loader_pkg::*;

    localparam int unsigned CLK_HZ = 10_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    pg_prog_if pif ();

    pg_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .uart_rx_i (rx),
        .pg_rst_o  (pif.pg_rst),
        .pg_wen_o  (pif.pg_wen),
        .pg_din_o  (pif.pg_din),
        .pg_adr_o  (pif.pg_adr),
        .pg_done_o (pif.pg_done),
        .err_o     (pif.err),
        .busy_o    (pif.busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rst_seen = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst) begin
            if (pif.pg_rst) rst_seen++;
            if (pif.pg_wen || pif.pg_rst)
                chk("wen_rst_excl", {31'd0, pif.pg_wen & pif.pg_rst}, 32'd0);
            if (pif.pg_wen) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_write observed=%0h expected=none",
                           {pif.pg_adr, pif.pg_din});
                end
                if (exp_q.size() > 0)
                    chk("write", {pif.pg_adr, pif.pg_din}, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] w[$], input bit bad_ck);
        logic [7:0]  sum;
        logic [15:0] adr;
        logic [15:0] n;
        sum = 8'h00;
        adr = 16'h0000;
        n   = 16'(w.size());
        send_byte(SYNC_BYTE);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        foreach (w[i]) begin
            exp_q.push_back({adr, w[i]});
            sum = sum + w[i][7:0] + w[i][15:8];
            adr = adr + 16'd1;
            send_byte(w[i][7:0]);
            send_byte(w[i][15:8]);
        end
        send_byte(bad_ck ? 8'h00 : sum);
    endtask

    task automatic check_end(input string tag, input logic done_e,
                             input logic err_e, input int rst_exp);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, {31'd0, pif.pg_done}, {31'd0, done_e});
        chk({tag, "_err"}, {31'd0, pif.err}, {31'd0, err_e});
        chk({tag, "_busy"}, {31'd0, pif.busy}, 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
        chk({tag, "_rstpulses"}, rst_seen, rst_exp);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rst"}, {31'd0, pif.pg_rst}, 32'd0);
        chk({tag, "_wen"}, {31'd0, pif.pg_wen}, 32'd0);
        chk({tag, "_din"}, {16'd0, pif.pg_din}, 32'd0);
        chk({tag, "_adr"}, {16'd0, pif.pg_adr}, 32'd0);
        chk({tag, "_done"}, {31'd0, pif.pg_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, pif.err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, pif.busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] w[$];
        int r0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // basic two-word frame
        r0 = rst_seen;
        w = '{16'h1234, 16'h5678};
        send_frame(w, 1'b0);
        check_end("frameA", 1'b1, 1'b0, r0 + 1);

        // checksum byte 00 (wrong when checking is built in)
        r0 = rst_seen;
        send_frame(w, 1'b1);
`ifdef PG_LOADER_CKSUM_EN
        check_end("badck", 1'b0, 1'b1, r0 + 1);
`else
        check_end("badck", 1'b1, 1'b0, r0 + 1);
`endif

        // zero-length frame
        r0 = rst_seen;
        w = {};
        send_frame(w, 1'b0);
        check_end("len0", 1'b1, 1'b0, r0 + 1);

        // junk before sync
        r0 = rst_seen;
        send_byte(8'h11);
        send_byte(8'h22);
        w = '{16'hABCD};
        send_frame(w, 1'b0);
        check_end("junk", 1'b1, 1'b0, r0 + 1);

        // framing error on the 4th byte, then recovery
        r0 = rst_seen;
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34, 1'b0);
        check_end("ferr", 1'b0, 1'b1, r0 + 1);
        r0 = rst_seen;
        w = '{16'hCAFE, 16'hF00D, 16'h0001};
        send_frame(w, 1'b0);
        check_end("recover", 1'b1, 1'b0, r0 + 1);

        // reset mid-frame after first word, with a byte in flight
        exp_q.push_back({16'h0000, 16'h2211});
        send_byte(SYNC_BYTE);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("mid_pending", exp_q.size(), 32'd0);
        chk("mid_adr", {16'd0, pif.pg_adr}, 32'd1);
        chk("mid_busy", {31'd0, pif.busy}, 32'd1);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rx  = 1'b1;
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        r0 = rst_seen;
        w = '{16'hBEEF};
        send_frame(w, 1'b0);
        check_end("fresh", 1'b1, 1'b0, r0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
